// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: sequences a W-bit add/subtract through an external 4-bit adder one nibble per cycle
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_cin,
  input  logic                   in_sub,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_sum,
  output logic                   out_cout,
  output logic                   out_ovf,
  output logic                   busy
);
  localparam int W  = 4*NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state;
  logic [W-1:0]  a_r, b_r;
  logic          carry;
  logic [IW-1:0] idx;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign out_ovf   = (a_r[W-1] == b_r[W-1]) && (out_sum[W-1] != a_r[W-1]);
  // adder operands are only presented while a nibble is being processed
  always_comb begin
    add_a   = state == RUN ? a_r[4*idx +: 4] : 4'h0;
    add_b   = state == RUN ? b_r[4*idx +: 4] : 4'h0;
    add_cin = state == RUN ? carry : 1'b0;
  end
  // controller: latch operands, walk nibbles LSB first, hold result until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r      <= in_a;
          b_r      <= in_sub ? ~in_b : in_b;
          carry    <= in_sub | in_cin;
          idx      <= '0;
          out_sum  <= '0;
          out_cout <= 1'b0;
          state    <= RUN;
        end
        RUN: begin
          out_sum[4*idx +: 4] <= add_sum;
          carry               <= add_cout;
          if (idx == IW'(NIBBLES-1)) begin
            out_cout <= add_cout;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: random and directed checks against an arithmetic reference model
module tb_nibble_serial_add_ctrl;
  localparam int N = 4;
  localparam int W = 4*N;
  logic clk = 0, rst = 1, in_valid = 0, in_cin = 0, in_sub = 0, out_ready = 0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic in_ready, add_cin, add_cout, out_valid, out_cout, out_ovf, busy;
  logic [3:0] add_a, add_b, add_sum;
  logic [W-1:0] out_sum;
  logic [W-1:0] exp_sum = '0;
  logic exp_cout = 0, exp_ovf = 0;
  int errs = 0, checks = 0;

  nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_sub(in_sub), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .busy(busy));

  always #5 clk = ~clk;
  assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    logic [W-1:0] bp;
    logic [W:0] f;
    bp = sub ? ~b : b;
    f = (W+1)'(a) + (W+1)'(bp) + (W+1)'(sub ? 1'b1 : cin);
    return {(a[W-1] == bp[W-1]) && (f[W-1] != a[W-1]), f};
  endfunction

  always @(negedge clk) if (!rst) begin
    chk("in_ready_vs_busy", 32'(in_ready), 32'(!busy));
    if (out_valid) begin
      chk("out_sum", 32'(out_sum), 32'(exp_sum));
      chk("out_cout", 32'(out_cout), 32'(exp_cout));
      chk("out_ovf", 32'(out_ovf), 32'(exp_ovf));
    end
    if (!busy || out_valid) chk("adder_idle", 32'({add_a, add_b, add_cin}), 32'(0));
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub,
                       input int hold, input bit lit, input logic [W-1:0] es, input logic ec, input logic eo);
    logic [W+1:0] m;
    logic [W-1:0] bp;
    logic [31:0] t, mask;
    m = model(a, b, cin, sub);
    if (lit) chk("model_pin", 32'(m), 32'({eo, ec, es}));
    {exp_ovf, exp_cout, exp_sum} = m;
    bp = sub ? ~b : b;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1;
    out_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom); in_sub = 1'($urandom);
    for (int k = 0; k < N; k++) begin
      mask = (32'(1) << (4*k)) - 1;
      t = (32'(a) & mask) + (32'(bp) & mask) + 32'(sub ? 1'b1 : cin);
      chk("run_valid", 32'(out_valid), 32'(0));
      chk("run_busy", 32'(busy), 32'(1));
      chk("run_add_a", 32'(add_a), (32'(a) >> (4*k)) & 32'hF);
      chk("run_add_b", 32'(add_b), (32'(bp) >> (4*k)) & 32'hF);
      chk("run_add_cin", 32'(add_cin), (t >> (4*k)) & 32'h1);
      @(posedge clk); #1;
    end
    chk("latency_valid", 32'(out_valid), 32'(1));
    for (int h = 0; h < hold; h++) begin
      out_ready = 0;
      in_a = W'($urandom); in_b = W'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'(1));
      chk("hold_in_ready", 32'(in_ready), 32'(0));
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("post_hs_valid", 32'(out_valid), 32'(0));
    chk("post_hs_in_ready", 32'(in_ready), 32'(1));
    in_valid = 0; out_ready = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_outs", 32'({out_sum, out_cout, out_ovf}), 32'(0));
    chk("rst_adder", 32'({add_a, add_b, add_cin}), 32'(0));
    rst = 0;
    do_op(16'h1234, 16'h0FFF, 0, 0, 0, 1, 16'h2233, 0, 0);
    do_op(16'h000E, 16'h000E, 1, 0, 1, 1, 16'h001D, 0, 0);
    do_op(16'hFFFF, 16'h0001, 0, 0, 0, 1, 16'h0000, 1, 0);
    do_op(16'h0005, 16'h0007, 1, 1, 3, 1, 16'hFFFE, 0, 0);
    do_op(16'h7FFF, 16'h0001, 0, 0, 0, 1, 16'h8000, 0, 1);
    do_op(16'h8000, 16'h0001, 0, 1, 2, 1, 16'h7FFF, 1, 1);
    in_a = 16'hAAAA; in_b = 16'h5555; in_cin = 0; in_sub = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    rst = 0; in_valid = 0; out_ready = 0;
    chk("abort_out_valid", 32'(out_valid), 32'(0));
    chk("abort_in_ready", 32'(in_ready), 32'(1));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_out_sum", 32'(out_sum), 32'(0));
    chk("abort_adder", 32'({add_a, add_b, add_cin}), 32'(0));
    do_op(16'h1234, 16'h0FFF, 0, 0, 0, 1, 16'h2233, 0, 0);
    for (int i = 0; i < 40; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3), 0, '0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
